shift_seq: RTL
==============

Name: shift_seq

Overview:
- Sequential front-end for the team's 8-bit arithmetic right shifter, which takes a 3-bit shift amount.
- Accepts an operand and a 4-bit shift amount (0..15) over a valid/ready handshake.
- Performs the shift as one or more shifter passes of at most 7 bits each.
- Presents the result on a valid/ready output port, so shifts wider than the combinational stage's range are supported.

Parameters:
- DATA_W, 8, operand/result width; fixed at 8 to match the shifter datapath.
- AMT_W, 4, shift-amount width; a request of up to 15 needs at most 3 passes.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request this cycle.
- in_data  input  8  signed operand.
- in_amt  input  4  arithmetic right-shift amount, 0..15.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  8  shifted result.
- busy  output  1  high in SHIFT or DONE state.

Behaviour:
- Function: out_data = signed(in_data) >>> in_amt. Amounts of 8 or more saturate to full sign fill: 0x00 for a non-negative operand, 0xFF for a negative one.
- Registers: acc[7:0] holds the working operand; rem[3:0] holds the remaining amount.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: acc<=in_data, rem<=in_amt.
  - Next state is DONE if in_amt==0, else SHIFT.
- SHIFT, one pass per cycle:
  - step = min(rem,7), driven as the shifter select.
  - acc <= ASR(acc, step); rem <= rem - step.
  - When rem - step == 0, next state is DONE; otherwise stay in SHIFT.
  - in_ready=0.
- DONE:
  - out_valid=1 and out_data=acc, both held stable until out_ready.
  - On out_valid&&out_ready: with in_valid=1, capture the new request (as in IDLE) and go to SHIFT or DONE; otherwise go to IDLE.
  - in_ready = out_ready in this state, so back-to-back requests lose no cycle.
- Latency, from the accept edge to out_valid high:
  - amt 0: 1 cycle.
  - amt 1..7: 2 cycles.
  - amt 8..14: 3 cycles.
  - amt 15: 4 cycles (passes of 7, 7, 1).
- Throughput: one result per (latency) cycles when out_ready is held high.
- in_valid without in_ready (during SHIFT, or DONE with out_ready=0) is ignored. The upstream must hold its request under standard valid/ready rules.
- out_data is driven from acc at all times but is meaningful only while out_valid=1.
- Reset (asynchronous, rst_n=0):
  - state=IDLE, acc=0x00, rem=0, out_valid=0, busy=0.
  - in_ready returns to 1 on the first clock after release.
  - Reset mid-SHIFT or in DONE discards the in-flight request and produces no output.
- No combinational path from in_valid to out_valid. The only combinational paths are out_ready to in_ready (DONE state) and rem to the shifter select.

Decomposition:
- Shared package holds:
  - DATA_W, AMT_W.
  - MAX_STEP=7.
  - State enum {IDLE, SHIFT, DONE}.
- One sub-module instance: the existing 8-bit arithmetic right shifter (Barrel_shifter), inputs acc and step[2:0], output feeding acc.
- FSM and handshake logic live in shift_seq itself.

Test Plan:
- Basic shift: in_data=0x80, in_amt=3, out_ready=1 -> out_data=0xF0, out_valid high 2 cycles after accept, low the next cycle.
- Zero shift: in_data=0x7F, in_amt=0 -> out_data=0x7F, 1 cycle after accept, with no SHIFT-state cycle.
- Multi-pass, negative operand: in_data=0x96, in_amt=15 -> out_data=0xFF after 4 cycles.
- Multi-pass, positive operand: in_data=0x40, in_amt=9 -> out_data=0x00 after 3 cycles.
- Multi-pass, large positive operand: in_data=0x7F, in_amt=8 -> out_data=0x00.
- Backpressure: result 0xE5 ready with out_ready=0 for 5 cycles while in_valid=1 -> out_data stable at 0xE5, in_ready=0, no capture. Raising out_ready hands off 0xE5 and captures the pending request in the same cycle.
- Back-to-back: requests (0x10,1) then (0xC0,2) with in_valid and out_ready held high -> outputs 0x08 then 0xF0, second accept on the same cycle as the first hand-off.
- Reset mid-SHIFT: accept (0x80,15), pulse rst_n low during the second pass -> out_valid stays 0, in_ready=1 after release, next request (0x04,2) -> 0x01.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared widths, pass limit and FSM states for the sequential arithmetic right shifter.
package shift_seq_pkg;

    localparam int DATA_W   = 8;
    localparam int AMT_W    = 4;
    localparam int MAX_STEP = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/Barrel_shifter.sv
// 8-bit arithmetic right shifter, shift amount 0..7, purely combinational.
module Barrel_shifter (
    input  logic [7:0] data_in,
    input  logic [2:0] shamt,
    output logic [7:0] data_out
);

    assign data_out = $signed(data_in) >>> shamt;

endmodule

// File: rtl/shift_seq.sv
// Arithmetic right shift of 0..15 built from passes of at most 7 bits through the barrel shifter.
// Latency 1 + ceil(amt/7) cycles accept-to-valid; result held until out_ready, in_ready follows out_ready in DONE.
module shift_seq
    import shift_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [AMT_W-1:0]    in_amt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                busy
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [AMT_W-1:0]    rem_q, rem_d;
    logic [2:0]          step;
    logic [DATA_W-1:0]   shift_out;

    assign step = (rem_q > AMT_W'(MAX_STEP)) ? 3'(MAX_STEP) : rem_q[2:0];

    Barrel_shifter u_barrel_shifter (
        .data_in  (acc_q),
        .shamt    (step),
        .data_out (shift_out)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = in_data;
                    rem_d   = in_amt;
                    state_d = (in_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = shift_out;
                rem_d   = rem_q - {1'b0, step};
                state_d = (rem_d == '0) ? DONE : SHIFT;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    // Hand-off and next capture share one edge so streams run without a bubble.
                    if (in_valid) begin
                        acc_d   = in_data;
                        rem_d   = in_amt;
                        state_d = (in_amt == '0) ? DONE : SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
        end
    end

    assign out_data = acc_q;
    assign busy     = (state_q != IDLE);

endmodule
